// File: rtl/float_to_fixed_if.sv
// Handshake bundle between the float adder result stage and float_to_fixed.
//   z/ovf_in/in_valid/in_ready      : operand side (master drives z, ovf_in, in_valid)
//   q/sat/nan/inexact/out_valid/out_ready : result side (slave drives results)
interface float_to_fixed_if;
    logic [31:0] z;
    logic [1:0]  ovf_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] q;
    logic        sat;
    logic        nan;
    logic        inexact;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output z, ovf_in, in_valid, out_ready,
        input  in_ready, q, sat, nan, inexact, out_valid
    );

    modport slave (
        input  z, ovf_in, in_valid, out_ready,
        output in_ready, q, sat, nan, inexact, out_valid
    );
endinterface

// File: rtl/float_to_fixed.sv
// Converts an IEEE-754 single (plus the adder's 2-bit status) into a 32-bit
// signed Q(31-FRAC_BITS).FRAC_BITS value, truncating toward zero. The mantissa
// is aligned by an iterative shifter moving one bit per cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : float_to_fixed_if.slave -- operand in (z, ovf_in, in_valid/in_ready)
//          and result out (q, sat, nan, inexact, out_valid/out_ready)
//
// state  | meaning
// IDLE   | waiting for an operand, in_ready=1
// DECODE | classify operand, load shifter or resolve special case
// SHIFT  | align mantissa one bit per cycle
// DONE   | result presented until out_ready
module float_to_fixed #(
    parameter int FRAC_BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    float_to_fixed_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DECODE, SHIFT, DONE} state_t;

    // Binary point of the 24-bit mantissa sits 23 bits up; exponent bias 127.
    localparam logic signed [9:0] K_OFF = 10'(FRAC_BITS - 150);

    state_t      state;
    logic [31:0] z_reg;
    logic [1:0]  ovf_reg;
    logic [31:0] mag;
    logic [4:0]  count;
    logic        left;
    logic        sticky;
    logic [31:0] q_reg;
    logic        sat_reg;
    logic        nan_reg;
    logic        inexact_reg;
    logic        out_valid_reg;

    logic [7:0]        e;
    logic [22:0]       m;
    logic              sign;
    logic signed [9:0] k;
    logic [31:0]       mag_init;
    logic [31:0]       sat_val;
    logic [31:0]       mag_shift;
    logic              sticky_next;

    assign sign     = z_reg[31];
    assign e        = z_reg[30:23];
    assign m        = z_reg[22:0];
    assign k        = $signed({2'b00, e}) + K_OFF;
    assign mag_init = {8'd0, 1'b1, m};
    assign sat_val  = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;

    assign mag_shift   = left ? {mag[30:0], 1'b0} : {1'b0, mag[31:1]};
    assign sticky_next = sticky | (~left & mag[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            z_reg         <= '0;
            ovf_reg       <= '0;
            mag           <= '0;
            count         <= '0;
            left          <= 1'b0;
            sticky        <= 1'b0;
            q_reg         <= '0;
            sat_reg       <= 1'b0;
            nan_reg       <= 1'b0;
            inexact_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        z_reg   <= bus.z;
                        ovf_reg <= bus.ovf_in;
                        state   <= DECODE;
                    end
                end

                DECODE: begin
                    mag           <= mag_init;
                    sticky        <= 1'b0;
                    left          <= ~k[9];
                    count         <= k[9] ? 5'(-k) : 5'(k);
                    sat_reg       <= 1'b0;
                    nan_reg       <= 1'b0;
                    inexact_reg   <= 1'b0;
                    out_valid_reg <= 1'b1;
                    state         <= DONE;
                    if (ovf_reg == 2'b11 || (e == 8'hFF && m != '0)) begin
                        q_reg   <= '0;
                        nan_reg <= 1'b1;
                    end else if (ovf_reg == 2'b01 || e == 8'hFF) begin
                        q_reg   <= sat_val;
                        sat_reg <= 1'b1;
                    end else if (ovf_reg == 2'b10 || e == 8'h00) begin
                        // Denormals flush to zero.
                        q_reg       <= '0;
                        inexact_reg <= (ovf_reg == 2'b10) || (m != '0);
                    end else if (k > 10'sd7) begin
                        // -2^(31-FRAC_BITS) is the one representable value here.
                        if (sign && m == '0 && k == 10'sd8) begin
                            q_reg <= 32'h8000_0000;
                        end else begin
                            q_reg   <= sat_val;
                            sat_reg <= 1'b1;
                        end
                    end else if (k <= -10'sd25) begin
                        q_reg       <= '0;
                        inexact_reg <= 1'b1;
                    end else if (k == 10'sd0) begin
                        q_reg <= sign ? -mag_init : mag_init;
                    end else begin
                        out_valid_reg <= 1'b0;
                        state         <= SHIFT;
                    end
                end

                SHIFT: begin
                    mag    <= mag_shift;
                    sticky <= sticky_next;
                    count  <= count - 5'd1;
                    if (count == 5'd1) begin
                        q_reg         <= sign ? -mag_shift : mag_shift;
                        inexact_reg   <= sticky_next;
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.q         = q_reg;
    assign bus.sat       = sat_reg;
    assign bus.nan       = nan_reg;
    assign bus.inexact   = inexact_reg;
    assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_float_to_fixed.sv
// Self-checking bench for float_to_fixed: directed and random operands are
// scored against a value-level reference model through an expectation queue.
module tb_float_to_fixed;

    localparam int FRAC_BITS = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    float_to_fixed_if bus ();

    float_to_fixed #(.FRAC_BITS(FRAC_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] q;
        logic        sat;
        logic        nan;
        logic        inexact;
        int          n;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    bit   stall_force = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Value-level model: result = (-1)^s * 1.m * 2^(e-127) scaled by 2^FRAC_BITS,
    // truncated toward zero and clamped to the 32-bit signed range.
    function automatic exp_t model(input logic [31:0] zz, input logic [1:0] ov);
        exp_t   r;
        int     e;
        int     k;
        int     sh;
        logic [22:0] m;
        logic   s;
        longint mag;
        longint val;
        longint lim;
        bit     big;
        r.q = '0; r.sat = 1'b0; r.nan = 1'b0; r.inexact = 1'b0; r.n = 0; r.acc = 0;
        s = zz[31];
        e = int'(zz[30:23]);
        m = zz[22:0];
        if (ov == 2'b11 || (e == 255 && m != '0)) begin
            r.nan = 1'b1;
        end else if (ov == 2'b01 || e == 255) begin
            r.sat = 1'b1;
            r.q   = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (ov == 2'b10 || e == 0) begin
            r.inexact = (ov == 2'b10) || (m != '0);
        end else begin
            k   = e - 127 + FRAC_BITS - 23;
            mag = longint'(m) + (longint'(1) << 23);
            if (k >= -24 && k <= 7) r.n = (k < 0) ? -k : k;
            if (k >= 0) begin
                big = (k > 31);
                val = big ? 64'd0 : (mag << k);
                lim = s ? (longint'(1) << 31) : ((longint'(1) << 31) - 1);
                if (big || val > lim) begin
                    r.sat = 1'b1;
                    r.q   = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                end else begin
                    r.q = s ? 32'(-val) : 32'(val);
                end
            end else begin
                sh = -k;
                if (sh >= 32) begin
                    val = 0;
                    r.inexact = 1'b1;
                end else begin
                    val = mag >> sh;
                    r.inexact = (mag & ((longint'(1) << sh) - 1)) != 0;
                end
                r.q = s ? 32'(-val) : 32'(val);
            end
        end
        return r;
    endfunction

    // Waits for in_ready, driving junk (possibly with in_valid) while busy so a
    // wrongly accepted operand would corrupt the scored stream.
    task automatic send(input logic [31:0] zz, input logic [1:0] ov);
        exp_t r;
        bit   done;
        done = 1'b0;
        r = model(zz, ov);
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                bus.z        = zz;
                bus.ovf_in   = ov;
                bus.in_valid = 1'b1;
                r.acc        = cyc + 1;
                sb.push_back(r);
                done = 1'b1;
            end else begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.z        = $urandom;
                bus.ovf_in   = 2'($urandom);
            end
        end
        if (done) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready never seen for z=%h", zz);
        end
    endtask

    // Monitor: owns out_ready, checks latency, stall stability and results.
    initial begin
        logic        prev_valid;
        logic [31:0] held_q;
        logic [2:0]  held_f;
        int          hold;
        exp_t        ex;
        prev_valid    = 1'b0;
        held_q        = '0;
        held_f        = '0;
        hold          = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_valid    = 1'b0;
                bus.out_ready = 1'b0;
            end else begin
                if (bus.out_valid) begin
                    if (!prev_valid) begin
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_output: q=%h with empty queue", bus.q);
                        end else begin
                            check("latency", 32'(cyc), 32'(sb[0].acc + sb[0].n + 1));
                        end
                        held_q = bus.q;
                        held_f = {bus.sat, bus.nan, bus.inexact};
                        if (stall_force) begin
                            hold = 5;
                            stall_force = 1'b0;
                        end else begin
                            hold = $urandom_range(0, 3);
                        end
                    end else begin
                        check("stall_q_stable", bus.q, held_q);
                        check("stall_flags_stable", 32'({bus.sat, bus.nan, bus.inexact}), 32'(held_f));
                    end
                    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
                    if (hold > 0) begin
                        hold--;
                        bus.out_ready = 1'b0;
                    end else begin
                        bus.out_ready = 1'b1;
                        if (sb.size() > 0) begin
                            ex = sb.pop_front();
                            check("q", bus.q, ex.q);
                            check("sat", 32'(bus.sat), 32'(ex.sat));
                            check("nan", 32'(bus.nan), 32'(ex.nan));
                            check("inexact", 32'(bus.inexact), 32'(ex.inexact));
                        end
                    end
                end else begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                prev_valid = bus.out_valid;
            end
        end
    end

    task automatic drain();
        for (int t = 0; t < 3000 && sb.size() > 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_q"}, bus.q, 32'd0);
        check({tag, "_flags"}, 32'({bus.sat, bus.nan, bus.inexact}), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] zz;
        logic [1:0]  ov;
        int          e;
        bus.z        = '0;
        bus.ovf_in   = '0;
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        send(32'h3FC0_0000, 2'b00);  // 1.5
        send(32'hC000_0000, 2'b00);  // -2.0
        send(32'h471C_4000, 2'b00);  // 40000.0 saturates
        send(32'hC700_0000, 2'b00);  // -32768.0 exact
        send(32'h7FC0_0000, 2'b00);  // NaN
        send(32'hC2B5_999A, 2'b01);  // overflow code
        send(32'h3586_37BD, 2'b00);  // ~1e-6
        stall_force = 1'b1;
        send(32'h3F80_0000, 2'b00);  // 1.0, held 5 cycles in DONE
        send(32'h4049_0FDB, 2'b00);  // pi, inexact
        send(32'h8000_0000, 2'b00);  // -0.0
        send(32'h0000_0001, 2'b00);  // denormal
        send(32'h7F80_0000, 2'b00);  // +inf
        send(32'h4700_0000, 2'b00);  // +32768.0 saturates
        send(32'h3F80_0000, 2'b10);  // underflow code
        send(32'h3F80_0000, 2'b11);  // invalid code
        send(32'h3700_0001, 2'b00);  // k=-24, shifts out everything
        send(32'hBF80_0001, 2'b00);  // -1.0000001
        send(32'h4680_0000, 2'b00);  // k=7, 16384.0
        send(32'h3780_0000, 2'b00);  // smallest step 2^-16

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 9))
                0:       e = 0;
                1:       e = 255;
                default: e = $urandom_range(100, 145);
            endcase
            zz = $urandom;
            zz[30:23] = 8'(e);
            ov = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            send(zz, ov);
        end
        drain();

        // Asynchronous reset in the middle of a long shift.
        send(32'h3700_0001, 2'b00);
        mon_en = 1'b0;
        sb.delete();
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("after_reset");
        mon_en = 1'b1;
        send(32'h3FC0_0000, 2'b00);
        send(32'hC000_0000, 2'b00);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
